// File: rtl/e1_fixed_point_reader.sv
// E1 fixed-point reader: sweeps the operand buffer once per start pulse and
// streams (buf[i], buf[i+1], buf[i+2]) triples downstream, indices wrapping modulo GEN_NUM.
module e1_fixed_point_reader #(
    parameter int unsigned GEN_NUM       = 200,
    parameter int unsigned GEN_NUM_WIDTH = $clog2(GEN_NUM),
    parameter int unsigned N             = 64,
    parameter int unsigned Q             = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [GEN_NUM_WIDTH-1:0] index,
    output logic [GEN_NUM_WIDTH-1:0] index1,
    output logic [GEN_NUM_WIDTH-1:0] index2,
    input  logic [N-1:0]             fixed_point,
    input  logic [N-1:0]             fixed_point1,
    input  logic [N-1:0]             fixed_point2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_a,
    output logic [N-1:0]             out_b,
    output logic [N-1:0]             out_c,
    output logic [GEN_NUM_WIDTH-1:0] out_idx,
    output logic                     out_last
);

    localparam int unsigned               EW         = GEN_NUM_WIDTH + 1;
    localparam logic [GEN_NUM_WIDTH-1:0]  LAST_IDX   = GEN_NUM_WIDTH'(GEN_NUM - 1);
    localparam logic [EW-1:0]             GEN_NUM_EW = EW'(GEN_NUM);

    // Q is a pass-through format tag; only its range relative to N matters here.
    if (Q >= N) begin : g_bad_q
        $error("Q must be smaller than N");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [GEN_NUM_WIDTH-1:0]   r_ptr;
    logic [GEN_NUM_WIDTH-1:0]   w_ptr_nxt;
    logic                       r_busy;
    logic                       w_busy_nxt;
    logic                       r_done;
    logic                       w_done_nxt;
    logic                       r_valid;
    logic                       w_valid_nxt;
    logic                       r_last;
    logic                       w_last_nxt;
    logic [N-1:0]               r_a;
    logic [N-1:0]               w_a_nxt;
    logic [N-1:0]               r_b;
    logic [N-1:0]               w_b_nxt;
    logic [N-1:0]               r_c;
    logic [N-1:0]               w_c_nxt;
    logic [GEN_NUM_WIDTH-1:0]   r_idx;
    logic [GEN_NUM_WIDTH-1:0]   w_idx_nxt;
    logic [EW-1:0]              w_raw1;
    logic [EW-1:0]              w_raw2;
    logic [GEN_NUM_WIDTH-1:0]   w_index1;
    logic [GEN_NUM_WIDTH-1:0]   w_index2;
    logic                       w_load;

    // Wrap by compare-and-subtract so non-power-of-two buffer sizes work.
    always_comb begin
        w_raw1   = EW'(r_ptr) + EW'(1);
        w_raw2   = EW'(r_ptr) + EW'(2);
        w_index1 = (w_raw1 >= GEN_NUM_EW) ? GEN_NUM_WIDTH'(w_raw1 - GEN_NUM_EW)
                                          : GEN_NUM_WIDTH'(w_raw1);
        w_index2 = (w_raw2 >= GEN_NUM_EW) ? GEN_NUM_WIDTH'(w_raw2 - GEN_NUM_EW)
                                          : GEN_NUM_WIDTH'(w_raw2);
    end

    assign w_load = !r_valid || out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_c_nxt     = r_c;
        w_idx_nxt   = r_idx;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_load) begin
                    w_a_nxt     = fixed_point;
                    w_b_nxt     = fixed_point1;
                    w_c_nxt     = fixed_point2;
                    w_idx_nxt   = r_ptr;
                    w_last_nxt  = (r_ptr == LAST_IDX);
                    w_valid_nxt = 1'b1;
                    if (r_ptr == LAST_IDX) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_ptr_nxt = w_index1;
                    end
                end
            end
            S_DRAIN: begin
                // Final triple still in the output register; finish once it is taken.
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign index     = r_ptr;
    assign index1    = w_index1;
    assign index2    = w_index2;
    assign out_valid = r_valid;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_c     = r_c;
    assign out_idx   = r_idx;
    assign out_last  = r_last;

endmodule
